// File: rtl/axi_mem_req_arb.sv
// Round-robin arbiter sharing one SRAM-style memory port between NumReq requesters.
// Granted {source, id} pairs are kept in an in-order queue to steer responses back.
module axi_mem_req_arb #(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned IdWidth        = 4,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 8
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NumReq-1:0]                      req_valid_i,
    output logic [NumReq-1:0]                      req_ready_o,
    input  logic [NumReq*IdWidth-1:0]              req_id_i,
    input  logic [NumReq*AddrWidth-1:0]            req_addr_i,
    input  logic [NumReq-1:0]                      req_we_i,
    input  logic [NumReq*DataWidth-1:0]            req_wdata_i,
    output logic                                   mem_req_o,
    input  logic                                   mem_gnt_i,
    output logic [AddrWidth-1:0]                   mem_addr_o,
    output logic                                   mem_we_o,
    output logic [DataWidth-1:0]                   mem_wdata_o,
    input  logic                                   mem_rvalid_i,
    input  logic [DataWidth-1:0]                   mem_rdata_i,
    output logic [NumReq-1:0]                      rsp_valid_o,
    output logic [IdWidth-1:0]                     rsp_id_o,
    output logic [DataWidth-1:0]                   rsp_data_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]    outstanding_o,
    output logic                                   err_o
);

    localparam int unsigned SelW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    typedef enum logic {
        ST_FREE,
        ST_LOCKED
    } lock_state_e;

    lock_state_e     state_q, state_d;
    logic [SelW-1:0] lock_sel_q, lock_sel_d;
    logic [SelW-1:0] rr_q, rr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    logic [SelW-1:0]    src_mem_q [MaxOutstanding];
    logic [IdWidth-1:0] id_mem_q  [MaxOutstanding];

    logic            full;
    logic            push;
    logic            pop;
    logic            rr_found;
    logic [SelW-1:0] rr_sel;
    logic [SelW-1:0] sel;
    logic [SelW-1:0] head_src;

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin : rr_search
        int unsigned idx;
        idx      = 0;
        rr_sel   = '0;
        rr_found = 1'b0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            idx = (32'(rr_q) + i) % NumReq;
            if (!rr_found && req_valid_i[SelW'(idx)]) begin
                rr_sel   = SelW'(idx);
                rr_found = 1'b1;
            end
        end
    end

    assign sel       = (state_q == ST_LOCKED) ? lock_sel_q : rr_sel;
    assign full      = (cnt_q == CntW'(MaxOutstanding));
    assign mem_req_o = (|req_valid_i) & ~full;
    assign push      = mem_req_o & mem_gnt_i;
    assign pop       = mem_rvalid_i & (cnt_q != '0);
    assign head_src  = src_mem_q[rd_ptr_q];

    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        if (mem_req_o) begin
            mem_addr_o  = req_addr_i[32'(sel)*AddrWidth +: AddrWidth];
            mem_we_o    = req_we_i[sel];
            mem_wdata_o = req_wdata_i[32'(sel)*DataWidth +: DataWidth];
        end
    end

    assign req_ready_o   = push ? (NumReq'(1) << sel) : '0;
    assign rsp_valid_o   = pop ? (NumReq'(1) << head_src) : '0;
    assign rsp_id_o      = pop ? id_mem_q[rd_ptr_q] : '0;
    assign rsp_data_o    = mem_rdata_i;
    assign outstanding_o = cnt_q;
    assign err_o         = err_q;

    // Lock FSM plus round-robin pointer, queue pointers and occupancy.
    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        rr_d       = rr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        err_d      = err_q | (mem_rvalid_i & (cnt_q == '0));

        case (state_q)
            ST_FREE: begin
                if (mem_req_o && !mem_gnt_i) begin
                    state_d    = ST_LOCKED;
                    lock_sel_d = rr_sel;
                end
            end
            ST_LOCKED: begin
                if (push) begin
                    state_d = ST_FREE;
                end
            end
            default: state_d = ST_FREE;
        endcase

        if (push) begin
            rr_d     = (sel == SelW'(NumReq - 1)) ? '0 : sel + SelW'(1);
            wr_ptr_d = (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_FREE;
            lock_sel_q <= '0;
            rr_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
            rr_q       <= rr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    // Queue payload needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            src_mem_q[wr_ptr_q] <= sel;
            id_mem_q[wr_ptr_q]  <= req_id_i[32'(sel)*IdWidth +: IdWidth];
        end
    end

endmodule

// File: tb/tb_axi_mem_req_arb.sv
// Randomized scoreboard bench for axi_mem_req_arb: a transaction-level arbitration
// model predicts grants and responses; an independent monitor checks each response.
module tb_axi_mem_req_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MO = 8;
    localparam int unsigned CW = $clog2(MO + 1);

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N-1:0]    req_valid_i;
    logic [N-1:0]    req_ready_o;
    logic [N*IW-1:0] req_id_i;
    logic [N*AW-1:0] req_addr_i;
    logic [N-1:0]    req_we_i;
    logic [N*DW-1:0] req_wdata_i;
    logic            mem_req_o;
    logic            mem_gnt_i;
    logic [AW-1:0]   mem_addr_o;
    logic            mem_we_o;
    logic [DW-1:0]   mem_wdata_o;
    logic            mem_rvalid_i;
    logic [DW-1:0]   mem_rdata_i;
    logic [N-1:0]    rsp_valid_o;
    logic [IW-1:0]   rsp_id_o;
    logic [DW-1:0]   rsp_data_o;
    logic [CW-1:0]   outstanding_o;
    logic            err_o;

    always #5 clk_i = ~clk_i;

    axi_mem_req_arb #(
        .NumReq(N), .IdWidth(IW), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_id_i(req_id_i),
        .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_wdata_i(req_wdata_i),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o),
        .rsp_data_o(rsp_data_o), .outstanding_o(outstanding_o), .err_o(err_o)
    );

    typedef struct { int due; logic [DW-1:0] data; } mem_rsp_t;
    typedef struct { int src; logic [IW-1:0] id; logic [DW-1:0] data; } exp_t;

    mem_rsp_t mem_q[$];
    exp_t     exp_q[$];
    exp_t     mon_e;
    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;

    // Per-requester pending transaction, held stable until granted.
    logic          t_valid [N];
    logic [IW-1:0] t_id    [N];
    logic [AW-1:0] t_addr  [N];
    logic          t_we    [N];
    logic [DW-1:0] t_wdata [N];

    // Reference state: last granted source, locked source (-1 none), occupancy, error.
    int   m_last, m_lock, m_count;
    logic m_err;

    int p_new, p_gnt, lat_max;
    bit hold_rsp, force_spur;

    function automatic logic [DW-1:0] rsp_fn(logic [AW-1:0] a, logic w, logic [DW-1:0] d);
        return w ? ~d : ({a[15:0], a[31:16]} ^ 32'h1234_5678);
    endfunction

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endfunction

    function automatic void set_txn(int k);
        t_valid[k] = 1'b1;
        t_id[k]    = IW'($urandom);
        t_addr[k]  = AW'($urandom);
        t_we[k]    = 1'($urandom);
        t_wdata[k] = DW'($urandom);
    endfunction

    function automatic void model_reset();
        m_last  = N - 1;
        m_lock  = -1;
        m_count = 0;
        m_err   = 1'b0;
        for (int k = 0; k < N; k++) t_valid[k] = 1'b0;
        mem_q.delete();
        exp_q.delete();
    endfunction

    task automatic drive_idle();
        req_valid_i  = '0;
        req_id_i     = '0;
        req_addr_i   = '0;
        req_we_i     = '0;
        req_wdata_i  = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        drive_idle();
        @(negedge clk_i);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_ready", req_ready_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_err", err_o, 0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cyc++;
    endtask

    task automatic step();
        logic         any, exp_req, exp_gnt, exp_pop;
        logic [N-1:0] exp_ready;
        int           cand;
        mem_rsp_t     mr;
        for (int k = 0; k < N; k++) begin
            if (!t_valid[k] && ($urandom_range(99) < 32'(p_new))) set_txn(k);
            req_valid_i[k]         = t_valid[k];
            req_id_i[k*IW +: IW]   = t_id[k];
            req_addr_i[k*AW +: AW] = t_addr[k];
            req_we_i[k]            = t_we[k];
            req_wdata_i[k*DW +: DW] = t_wdata[k];
        end
        mem_gnt_i    = ($urandom_range(99) < 32'(p_gnt));
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        if (force_spur) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = DW'($urandom);
        end else if (!hold_rsp && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            mr           = mem_q.pop_front();
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mr.data;
        end

        @(negedge clk_i);
        any = 1'b0;
        for (int k = 0; k < N; k++) any |= t_valid[k];
        exp_req = any && (m_count < int'(MO));
        cand = -1;
        if (m_lock >= 0) cand = m_lock;
        else begin
            for (int i = 1; i <= int'(N); i++) begin
                int k;
                k = (m_last + i) % int'(N);
                if (cand < 0 && t_valid[k]) cand = k;
            end
        end
        exp_gnt   = exp_req && mem_gnt_i;
        exp_ready = exp_gnt ? (N'(1) << cand) : '0;
        exp_pop   = mem_rvalid_i && (m_count > 0);

        chk("mem_req", mem_req_o, exp_req);
        chk("req_ready", req_ready_o, exp_ready);
        chk("mem_addr", mem_addr_o, exp_req ? t_addr[cand] : '0);
        chk("mem_we", mem_we_o, exp_req ? t_we[cand] : 1'b0);
        chk("mem_wdata", mem_wdata_o, exp_req ? t_wdata[cand] : '0);
        chk("rsp_strobe", (rsp_valid_o != '0), exp_pop);
        chk("outstanding", outstanding_o, m_count);
        chk("err", err_o, m_err);

        if (mem_req_o && mem_gnt_i)
            mem_q.push_back('{cyc + int'($urandom_range(lat_max, 1)),
                              rsp_fn(mem_addr_o, mem_we_o, mem_wdata_o)});

        if (exp_gnt) begin
            exp_q.push_back('{cand, t_id[cand], rsp_fn(t_addr[cand], t_we[cand], t_wdata[cand])});
            m_last       = cand;
            m_lock       = -1;
            t_valid[cand] = 1'b0;
        end else if (exp_req) begin
            m_lock = cand;
        end
        if (mem_rvalid_i && m_count == 0) m_err = 1'b1;
        m_count = m_count + (exp_gnt ? 1 : 0) - (exp_pop ? 1 : 0);

        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic drain();
        bit busy;
        p_new    = 0;
        p_gnt    = 100;
        hold_rsp = 1'b0;
        for (int i = 0; i < 200; i++) begin
            busy = (m_count != 0) || (mem_q.size() != 0);
            for (int k = 0; k < N; k++) busy |= t_valid[k];
            if (!busy) break;
            step();
        end
        chk("drain_outstanding", m_count, 0);
        chk("drain_scoreboard", exp_q.size(), 0);
    endtask

    // Response monitor: every strobe must match the oldest granted request.
    always @(negedge clk_i) begin
        if (!rst_i && rsp_valid_o != '0) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", rsp_valid_o, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_src", rsp_valid_o, N'(1) << mon_e.src);
                chk("rsp_id", rsp_id_o, mon_e.id);
                chk("rsp_data", rsp_data_o, mon_e.data);
            end
        end
    end

    initial begin
        rst_i      = 1'b1;
        drive_idle();
        p_new      = 0;
        p_gnt      = 100;
        lat_max    = 1;
        hold_rsp   = 1'b0;
        force_spur = 1'b0;
        model_reset();
        do_reset();

        // All requesters busy, memory always granting, single-cycle response.
        p_new = 100; p_gnt = 100; lat_max = 1;
        repeat (12) step();
        drain();

        // Lock: requester 2 stalled three cycles, requester 0 joins meanwhile.
        p_new = 0; p_gnt = 0;
        set_txn(2);
        step();
        set_txn(0);
        step();
        step();
        p_gnt = 100;
        step();
        step();
        drain();

        // Fill the queue with responses held back, then release them.
        p_new = 100; p_gnt = 100; hold_rsp = 1'b1;
        repeat (11) step();
        hold_rsp = 1'b0; lat_max = 1;
        repeat (8) step();
        drain();

        // Three outstanding, then steady push+pop.
        p_new = 100; p_gnt = 100; hold_rsp = 1'b1;
        repeat (3) step();
        hold_rsp = 1'b0; lat_max = 1;
        repeat (8) step();
        drain();

        // Random traffic, reset in the middle of it, then more traffic.
        p_new = 40; p_gnt = 60; lat_max = 4;
        repeat (400) step();
        do_reset();
        p_new = 50; p_gnt = 70; lat_max = 3;
        repeat (300) step();
        drain();

        // Spurious response with empty queue; the error must stick.
        force_spur = 1'b1;
        step();
        force_spur = 1'b0;
        p_new = 30; p_gnt = 80; lat_max = 2;
        repeat (100) step();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
